// File: rtl/unidade_controle_exp7_pkg.sv
// State encoding and per-state output decode for the exp7 memory-game control unit.
// Codes are fixed because the top-level hex display decodes db_estado.
package unidade_controle_exp7_pkg;

    typedef enum logic [4:0] {
        inicial         = 5'h00,
        preparacao      = 5'h01,
        mostra_primeira = 5'h02,
        inicia_rodada   = 5'h03,
        espera_jogada   = 5'h04,
        registra        = 5'h05,
        comparacao      = 5'h06,
        proxima_jogada  = 5'h07,
        incrementa      = 5'h08,
        espera_nova     = 5'h09,
        fim_acertou     = 5'h0A,
        registra_nova   = 5'h0C,
        grava           = 5'h0D,
        fim_errou       = 5'h0E,
        fim_timeout     = 5'h0F
    } estado_t;

    typedef struct packed {
        logic zeraE;
        logic contaE;
        logic zeraRod;
        logic contaRod;
        logic zeraT;
        logic contaT;
        logic zeraP;
        logic contaP;
        logic zeraR;
        logic registraR;
        logic we;
        logic sinal_led;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic timeout;
    } saidas_t;

    function automatic saidas_t decodifica(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            preparacao: begin
                s.zeraE   = 1'b1;
                s.zeraRod = 1'b1;
                s.zeraR   = 1'b1;
                s.zeraT   = 1'b1;
                s.zeraP   = 1'b1;
            end
            mostra_primeira: begin
                s.contaP    = 1'b1;
                s.sinal_led = 1'b1;
            end
            inicia_rodada: begin
                s.zeraE = 1'b1;
                s.zeraT = 1'b1;
            end
            espera_jogada, espera_nova: s.contaT = 1'b1;
            registra, registra_nova: begin
                s.registraR = 1'b1;
                s.zeraT     = 1'b1;
            end
            proxima_jogada: s.contaE = 1'b1;
            incrementa: begin
                s.contaE   = 1'b1;
                s.contaRod = 1'b1;
                s.zeraT    = 1'b1;
            end
            grava: s.we = 1'b1;
            fim_acertou: begin
                s.pronto = 1'b1;
                s.ganhou = 1'b1;
            end
            fim_errou: begin
                s.pronto = 1'b1;
                s.perdeu = 1'b1;
            end
            fim_timeout: begin
                s.pronto  = 1'b1;
                s.timeout = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_exp7.sv
// Moore control FSM for the exp7 memory game: show first play, check repetition, record a new play.
module unidade_controle_exp7
    import unidade_controle_exp7_pkg::*;
#(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimP,
    input  logic       fimT,
    input  logic       fimRod,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       jogada_feita,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraP,
    output logic       contaP,
    output logic       zeraR,
    output logic       registraR,
    output logic       we,
    output logic       sinal_led,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [4:0] db_estado
);

    estado_t estado, proximo;
    saidas_t saidas;
    logic    expirou;

    assign expirou = TIMEOUT_EN && fimT;

    always_comb begin
        proximo = inicial;
        case (estado)
            inicial:         proximo = iniciar ? preparacao : inicial;
            preparacao:      proximo = mostra_primeira;
            mostra_primeira: proximo = fimP ? inicia_rodada : mostra_primeira;
            inicia_rodada:   proximo = espera_jogada;
            espera_jogada:   proximo = jogada_feita ? registra :
                                       expirou      ? fim_timeout : espera_jogada;
            registra:        proximo = comparacao;
            comparacao: begin
                if (!igual)                         proximo = fim_errou;
                else if (enderecoIgualRodada && fimRod) proximo = fim_acertou;
                else if (enderecoIgualRodada)       proximo = incrementa;
                else                                proximo = proxima_jogada;
            end
            proxima_jogada:  proximo = espera_jogada;
            incrementa:      proximo = espera_nova;
            espera_nova:     proximo = jogada_feita ? registra_nova :
                                       expirou      ? fim_timeout : espera_nova;
            registra_nova:   proximo = grava;
            grava:           proximo = inicia_rodada;
            fim_acertou, fim_errou, fim_timeout:
                             proximo = iniciar ? preparacao : estado;
            default:         proximo = inicial;
        endcase
    end

    // Outputs are registered from the next-state decode, so they track the state register exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= inicial;
            saidas <= '0;
        end else begin
            estado <= proximo;
            saidas <= decodifica(proximo);
        end
    end

    assign zeraE     = saidas.zeraE;
    assign contaE    = saidas.contaE;
    assign zeraRod   = saidas.zeraRod;
    assign contaRod  = saidas.contaRod;
    assign zeraT     = saidas.zeraT;
    assign contaT    = saidas.contaT;
    assign zeraP     = saidas.zeraP;
    assign contaP    = saidas.contaP;
    assign zeraR     = saidas.zeraR;
    assign registraR = saidas.registraR;
    assign we        = saidas.we;
    assign sinal_led = saidas.sinal_led;
    assign pronto    = saidas.pronto;
    assign ganhou    = saidas.ganhou;
    assign perdeu    = saidas.perdeu;
    assign timeout   = saidas.timeout;
    assign db_estado = estado;

endmodule
